// File: rtl/serv_decode_queue.sv
// Small FIFO of pre-decoded RISC-V instruction words between the fetch bus and the core.
// Each fetched word is decoded on entry; only decoded fields are held in the queue.
module serv_decode_queue #(
   parameter int unsigned DEPTH         = 4,
   parameter bit          MDU           = 1'b0,
   parameter bit          ILLEGAL_CHECK = 1'b1
) (
   input  logic                       clk,
   input  logic                       i_rst_n,
   input  logic                       i_flush,
   input  logic [31:0]                i_wb_rdt,
   input  logic                       i_wb_en,
   output logic                       o_wb_rdy,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [4:0]                 o_opcode,
   output logic [2:0]                 o_funct3,
   output logic                       o_rd_op,
   output logic                       o_two_stage_op,
   output logic                       o_mdu_op,
   output logic                       o_csr_op,
   output logic                       o_illegal,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [4:0] opcode;
      logic [2:0] funct3;
      logic       rd_op;
      logic       two_stage_op;
      logic       mdu_op;
      logic       csr_op;
      logic       illegal;
   } entry_t;

   entry_t          entry_d;
   entry_t          head;
   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_d;
   logic            push;
   logic            pop;

   logic [4:0] opc;
   logic [2:0] f3;
   logic       is_op;
   logic       is_opimm;
   logic       legal_opc;

   assign opc      = i_wb_rdt[6:2];
   assign f3       = i_wb_rdt[14:12];
   assign is_op    = (opc == 5'b01100);
   assign is_opimm = (opc == 5'b00100);

   always_comb begin
      entry_d        = '0;
      entry_d.opcode = opc;
      entry_d.funct3 = f3;
      entry_d.mdu_op = MDU && is_op && i_wb_rdt[25];
      entry_d.rd_op  = opc inside {5'b00100, 5'b00101, 5'b01100, 5'b01101,
                                   5'b11100, 5'b11001, 5'b11011, 5'b00000};
      entry_d.csr_op = (opc == 5'b11100) && (f3 != 3'b000);
      // Shifts are funct3 x01, SLT/SLTU are funct3 01x, for both OP and OP-IMM
      entry_d.two_stage_op = (opc inside {5'b00000, 5'b01000, 5'b11000, 5'b11011, 5'b11001})
                             || ((is_op || is_opimm) && (f3[1:0] == 2'b01))
                             || ((is_op || is_opimm) && (f3[2:1] == 2'b01))
                             || entry_d.mdu_op;
      legal_opc = opc inside {5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                              5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100};
      entry_d.illegal = ILLEGAL_CHECK && ((i_wb_rdt[1:0] != 2'b11) || !legal_opc
                                          || (is_op && i_wb_rdt[25] && !MDU));
   end

   assign o_wb_rdy = (count_q != CW'(DEPTH));
   assign o_valid  = (count_q != '0);
   assign o_count  = count_q;
   assign push     = i_wb_en && o_wb_rdy && !i_flush;
   assign pop      = o_valid && i_ready && !i_flush;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (i_flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Entry storage is deliberately left unreset; o_valid gates every field.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= entry_d;
   end

   assign head           = o_valid ? mem_q[rd_ptr_q] : '0;
   assign o_opcode       = head.opcode;
   assign o_funct3       = head.funct3;
   assign o_rd_op        = head.rd_op;
   assign o_two_stage_op = head.two_stage_op;
   assign o_mdu_op       = head.mdu_op;
   assign o_csr_op       = head.csr_op;
   assign o_illegal      = head.illegal;

endmodule

// File: tb/tb_serv_decode_queue.sv
// Directed bench for serv_decode_queue; runs a default instance and an MDU=1 instance
// side by side on identical stimulus.
module tb_serv_decode_queue;

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic        i_flush;
   logic [31:0] i_wb_rdt;
   logic        i_wb_en;
   logic        i_ready;

   logic        wb_rdy, valid, rd_op, two_stage_op, mdu_op, csr_op, illegal;
   logic [4:0]  opcode;
   logic [2:0]  funct3;
   logic [2:0]  count;
   logic        wb_rdy_m, valid_m, rd_op_m, two_stage_op_m, mdu_op_m, csr_op_m, illegal_m;
   logic [4:0]  opcode_m;
   logic [2:0]  funct3_m;
   logic [2:0]  count_m;

   logic [12:0] head, head_m;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;

   always #5 clk = ~clk;

   serv_decode_queue #(.DEPTH(4), .MDU(1'b0), .ILLEGAL_CHECK(1'b1)) dut (
      .clk            (clk),
      .i_rst_n        (i_rst_n),
      .i_flush        (i_flush),
      .i_wb_rdt       (i_wb_rdt),
      .i_wb_en        (i_wb_en),
      .o_wb_rdy       (wb_rdy),
      .o_valid        (valid),
      .i_ready        (i_ready),
      .o_opcode       (opcode),
      .o_funct3       (funct3),
      .o_rd_op        (rd_op),
      .o_two_stage_op (two_stage_op),
      .o_mdu_op       (mdu_op),
      .o_csr_op       (csr_op),
      .o_illegal      (illegal),
      .o_count        (count)
   );

   serv_decode_queue #(.DEPTH(4), .MDU(1'b1), .ILLEGAL_CHECK(1'b1)) dut_m (
      .clk            (clk),
      .i_rst_n        (i_rst_n),
      .i_flush        (i_flush),
      .i_wb_rdt       (i_wb_rdt),
      .i_wb_en        (i_wb_en),
      .o_wb_rdy       (wb_rdy_m),
      .o_valid        (valid_m),
      .i_ready        (i_ready),
      .o_opcode       (opcode_m),
      .o_funct3       (funct3_m),
      .o_rd_op        (rd_op_m),
      .o_two_stage_op (two_stage_op_m),
      .o_mdu_op       (mdu_op_m),
      .o_csr_op       (csr_op_m),
      .o_illegal      (illegal_m),
      .o_count        (count_m)
   );

   // {opcode, funct3, rd_op, two_stage_op, mdu_op, csr_op, illegal}
   assign head   = {opcode, funct3, rd_op, two_stage_op, mdu_op, csr_op, illegal};
   assign head_m = {opcode_m, funct3_m, rd_op_m, two_stage_op_m, mdu_op_m, csr_op_m, illegal_m};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      i_wb_en  = 1'b1;
      i_wb_rdt = w;
      tick();
      i_wb_en  = 1'b0;
   endtask

   task automatic pop_one();
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
   endtask

   initial begin
      i_rst_n  = 1'b0;
      i_flush  = 1'b0;
      i_wb_rdt = '0;
      i_wb_en  = 1'b0;
      i_ready  = 1'b0;
      tick();
      tick();
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_wb_rdy", 32'(wb_rdy), 32'd1);
      check("rst_head", 32'(head), 32'd0);
      i_rst_n = 1'b1;

      // addi x1, x0, 5 -- not visible before the push edge
      i_wb_en  = 1'b1;
      i_wb_rdt = 32'h0050_0093;
      #1;
      check("latency_valid", 32'(valid), 32'd0);
      tick();
      i_wb_en = 1'b0;
      check("addi_valid", 32'(valid), 32'd1);
      check("addi_count", 32'(count), 32'd1);
      check("addi_head", 32'(head), 32'({5'b00100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
      pop_one();
      check("pop_empty_count", 32'(count), 32'd0);
      check("pop_empty_head", 32'(head), 32'd0);

      // Fill: addi, lw, sw, slli with consumer stalled
      push_word(32'h0050_0093);
      push_word(32'h0000_a103);
      push_word(32'h0020_a023);
      push_word(32'h0010_9093);
      check("full_count", 32'(count), 32'd4);
      check("full_wb_rdy", 32'(wb_rdy), 32'd0);
      push_word(32'h3401_1073);
      check("ignored_count", 32'(count), 32'd4);
      check("stall_head", 32'(head), 32'({5'b00100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));

      // Full with push+pop: pop only, then steady-state push+pop
      i_wb_en  = 1'b1;
      i_wb_rdt = 32'h0000_10b7;
      i_ready  = 1'b1;
      tick();
      check("fullpp_count", 32'(count), 32'd3);
      check("lw_head", 32'(head), 32'({5'b00000, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
      tick();
      i_wb_en = 1'b0;
      check("pp_count", 32'(count), 32'd3);
      check("sw_head", 32'(head), 32'({5'b01000, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
      tick();
      check("slli_count", 32'(count), 32'd2);
      check("slli_head", 32'(head), 32'({5'b00100, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
      tick();
      check("lui_count", 32'(count), 32'd1);
      check("lui_head", 32'(head), 32'({5'b01101, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
      tick();
      i_ready = 1'b0;
      check("drain_count", 32'(count), 32'd0);

      // mul, csrrw, all-ones word
      push_word(32'h0220_8033);
      check("mul_head_nomdu", 32'(head), 32'({5'b01100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}));
      check("mul_head_mdu", 32'(head_m), 32'({5'b01100, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}));
      push_word(32'h3401_1073);
      push_word(32'hffff_ffff);
      check("three_count", 32'(count), 32'd3);
      pop_one();
      check("csr_head", 32'(head), 32'({5'b11100, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}));
      pop_one();
      check("ones_head", 32'(head), 32'({5'b11111, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
      check("ones_count", 32'(count), 32'd1);
      pop_one();
      check("drain2_count", 32'(count_m), 32'd0);

      // Flush with three entries and a concurrent push
      push_word(32'h0050_0093);
      push_word(32'h0000_a103);
      push_word(32'h0020_a023);
      i_flush  = 1'b1;
      i_wb_en  = 1'b1;
      i_wb_rdt = 32'h0010_9093;
      tick();
      i_flush = 1'b0;
      i_wb_en = 1'b0;
      check("flush_count", 32'(count), 32'd0);
      check("flush_valid", 32'(valid), 32'd0);
      check("flush_head", 32'(head), 32'd0);
      push_word(32'h0000_a103);
      check("post_flush_head", 32'(head), 32'({5'b00000, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
      push_word(32'h0050_0093);
      check("post_flush_count", 32'(count), 32'd2);

      // Asynchronous reset between edges
      #2;
      i_rst_n = 1'b0;
      #1;
      check("async_valid", 32'(valid), 32'd0);
      check("async_count", 32'(count), 32'd0);
      check("async_wb_rdy", 32'(wb_rdy), 32'd1);
      check("async_head", 32'(head), 32'd0);
      #1;
      i_rst_n = 1'b1;
      push_word(32'h0050_0093);
      check("post_rst_count", 32'(count), 32'd1);
      check("post_rst_head", 32'(head), 32'({5'b00100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
